// File: rtl/vga_matrix_display.sv
// 4x4 matrix result viewer: double-buffered 16x16-bit banks painted as VGA cells; define GRID_LINES_EN for white cell borders.
// Latency: 2 clk_en pulses from timing inputs to rgb/hsync_out/vsync_out/blank_out.
// Backpressure: busy holds from commit until the next frame start; writes and commits are dropped meanwhile.
module vga_matrix_display #(
  parameter int CELL_W = 160,
  parameter int CELL_H = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic [10:0] h_count,
  input  logic [10:0] v_count,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblank_in,
  input  logic        vblank_in,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        commit,
  output logic        busy,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out,
  output logic [11:0] rgb
);

  localparam logic [10:0] CW1 = 11'(CELL_W);
  localparam logic [10:0] CW2 = 11'(2 * CELL_W);
  localparam logic [10:0] CW3 = 11'(3 * CELL_W);
  localparam logic [10:0] CH1 = 11'(CELL_H);
  localparam logic [10:0] CH2 = 11'(2 * CELL_H);
  localparam logic [10:0] CH3 = 11'(3 * CELL_H);

  logic [15:0] bank0 [16];
  logic [15:0] bank1 [16];
  logic        bank_sel;
  logic        vblank_prev;
  logic        frame_start;

  logic [1:0]  col_d, row_d;
  logic [1:0]  s1_col, s1_row;
  logic        s1_hsync, s1_vsync, s1_blank;
  logic [15:0] front_dat;
  logic [11:0] pix_rgb;

  assign frame_start = clk_en && vblank_in && !vblank_prev;

  // Bank storage, swap control and frame-edge detect share one reset domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
      bank_sel    <= 1'b0;
      busy        <= 1'b0;
      vblank_prev <= 1'b1;
    end else begin
      if (wr_en && !busy) begin
        if (bank_sel) bank0[wr_addr] <= wr_data;
        else          bank1[wr_addr] <= wr_data;
      end
      if (frame_start && busy) begin
        bank_sel <= ~bank_sel;
        busy     <= 1'b0;
      end else if (commit && !busy) begin
        busy <= 1'b1;
      end
      if (clk_en) vblank_prev <= vblank_in;
    end
  end

  // Cell index by compare chain; anything past the last boundary clamps to 3.
  always_comb begin
    col_d = 2'd0;
    if      (h_count >= CW3) col_d = 2'd3;
    else if (h_count >= CW2) col_d = 2'd2;
    else if (h_count >= CW1) col_d = 2'd1;
    row_d = 2'd0;
    if      (v_count >= CH3) row_d = 2'd3;
    else if (v_count >= CH2) row_d = 2'd2;
    else if (v_count >= CH1) row_d = 2'd1;
  end

`ifdef GRID_LINES_EN
  logic grid_d, s1_grid;
  assign grid_d = !(hblank_in || vblank_in) &&
                  (h_count == 11'd0 || h_count == CW1 || h_count == CW2 || h_count == CW3 ||
                   v_count == 11'd0 || v_count == CH1 || v_count == CH2 || v_count == CH3);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_col   <= 2'd0;
      s1_row   <= 2'd0;
      s1_hsync <= 1'b1;
      s1_vsync <= 1'b1;
      s1_blank <= 1'b1;
`ifdef GRID_LINES_EN
      s1_grid  <= 1'b0;
`endif
    end else if (clk_en) begin
      s1_col   <= col_d;
      s1_row   <= row_d;
      s1_hsync <= hsync_in;
      s1_vsync <= vsync_in;
      s1_blank <= hblank_in || vblank_in;
`ifdef GRID_LINES_EN
      s1_grid  <= grid_d;
`endif
    end
  end

  always_comb begin
    front_dat = bank_sel ? bank1[{s1_row, s1_col}] : bank0[{s1_row, s1_col}];
    pix_rgb   = front_dat[15:4];
`ifdef GRID_LINES_EN
    if (s1_grid) pix_rgb = 12'hFFF;
`endif
    if (s1_blank) pix_rgb = 12'h000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb       <= 12'h000;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      blank_out <= 1'b1;
    end else if (clk_en) begin
      rgb       <= pix_rgb;
      hsync_out <= s1_hsync;
      vsync_out <= s1_vsync;
      blank_out <= s1_blank;
    end
  end

endmodule

// File: doc/vga_matrix_display.md
VGA_MATRIX_DISPLAY -- requirements
Module: vga_matrix_display

Interface
REQ-001 SHALL have parameter CELL_W, default 160, cell width in pixels (640/4).
REQ-002 SHALL have parameter CELL_H, default 120, cell height in lines (480/4).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port clk_en  input  1  pixel-rate enable (one pulse per pixel).
REQ-006 SHALL have port h_count  input  11  horizontal position from horizontal counter.
REQ-007 SHALL have port v_count  input  11  vertical position from vertical counter.
REQ-008 SHALL have ports hsync_in, vsync_in, hblank_in, vblank_in  input  1 each  raw timing, syncs active-low.
REQ-009 SHALL have port wr_en  input  1  result write strobe from matrix multiplier.
REQ-010 SHALL have port wr_addr  input  4  cell index, row*4+col.
REQ-011 SHALL have port wr_data  input  16  result element.
REQ-012 SHALL have port commit  input  1  one-cycle pulse: back bank complete, request swap.
REQ-013 SHALL have port busy  output  1  swap pending; writes/commits ignored.
REQ-014 SHALL have ports hsync_out, vsync_out  output  1 each  timing delayed to match pixel data.
REQ-015 SHALL have port blank_out  output  1  hblank_out OR vblank_out, delayed.
REQ-016 SHALL have port rgb  output  12  {R[3:0],G[3:0],B[3:0]}.

Function
REQ-017 SHALL hold two 16x16-bit banks; front bank displayed, back bank written; bank_sel picks front.
REQ-018 SHALL write wr_data to back[wr_addr] on any clk cycle with wr_en=1 and busy=0, independent of clk_en.
REQ-019 SHALL set busy on commit=1 with busy=0; commit with busy=1 ignored.
REQ-020 SHALL detect frame start on a clk_en cycle where vblank_in=1 and registered previous vblank_in=0.
REQ-021 SHALL, at frame start with busy=1, toggle bank_sel and clear busy in the same cycle.
REQ-022 SHALL, when commit and frame start coincide with busy=0, set busy only; swap waits for next frame start.
REQ-023 SHALL pipeline two clk_en-qualified stages: S1 registers col=h_count/CELL_W, row=v_count/CELL_H (compare chain, no divider), grid flag, blank, syncs; S2 reads front[row*4+col], registers rgb and delayed syncs.
REQ-024 SHALL give latency of exactly 2 clk_en pulses from inputs to hsync_out/vsync_out/blank_out/rgb; registers hold when clk_en=0.
REQ-025 SHALL map rgb = wr_data[15:4] of the selected element when not blanked.
REQ-026 SHALL force rgb=12'h000 whenever delayed blank is 1.
REQ-027 SHALL clamp col/row to 3 for h_count>=4*CELL_W or v_count>=4*CELL_H (blanked anyway).

Reset
REQ-028 SHALL on reset clear both banks to 0, bank_sel=0, busy=0, previous-vblank register=1.
REQ-029 SHALL on reset drive rgb=0, hsync_out=1, vsync_out=1, blank_out=1, clearing both pipeline stages.
REQ-030 SHALL on reset mid-frame discard pending swap; first frame start after reset requires vblank 0->1 edge.

Configuration
REQ-031 SHALL honour macro GRID_LINES_EN: when defined, pixels with h_count%CELL_W==0 or v_count%CELL_H==0 in visible area output rgb=12'hFFF, overriding cell colour.
REQ-032 SHALL, without GRID_LINES_EN, output cell colour for every visible pixel and omit grid-flag logic.

Verification
REQ-033 SHALL test reset: assert reset mid-line -> next cycle rgb=0, hsync_out=1, vsync_out=1, blank_out=1, busy=0.
REQ-034 SHALL test latency: h_count=645..660 with hsync_in low at 656 -> hsync_out low exactly 2 clk_en pulses later; clk_en gaps stretch delay.
REQ-035 SHALL test swap: write back[5]=16'hABC0, commit mid-frame -> busy=1, rgb unchanged; after vblank rising, pixel (200,130) gives rgb=12'hABC, busy=0.
REQ-036 SHALL test busy drop: commit, then wr_en addr 0 data 16'h1230 before swap -> write ignored; commit and frame start same cycle -> swap deferred one frame.
REQ-037 SHALL test blanking: front[15]=16'hFFF0, h_count=700 -> rgb=0; h_count=639,v_count=479 -> rgb=12'hFFF.
REQ-038 SHALL test GRID_LINES_EN: defined -> h_count=160 on visible line gives 12'hFFF; undefined -> cell colour.
